// File: rtl/encoder_pkg.sv
// Shared types and widths for the 16-to-4 request encoder.
// Holds the FSM state enum and small bit-vector helpers.
package encoder_pkg;

    localparam int REQ_W = 16;
    localparam int IDX_W = 4;
    localparam int CNT_W = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // Number of set bits in a request vector (0..16).
    function automatic logic [CNT_W-1:0] popcount(
        input logic [REQ_W-1:0] v
    );
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < REQ_W; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

    // One-hot mask selecting a single request bit.
    function automatic logic [REQ_W-1:0] onehot(
        input logic [IDX_W-1:0] i
    );
        logic [REQ_W-1:0] m;
        m = '0;
        m[i] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/encoder_16x4_prio.sv
// Combinational 16-to-4 priority encoder.
// msb_first selects whether the highest or lowest set bit wins.
module encoder_16x4_prio
    import encoder_pkg::*;
(
    input  logic [REQ_W-1:0] req,
    input  logic             msb_first,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Later loop iterations override earlier ones, so the scan
    // order decides which set bit has priority.
    always_comb begin
        idx = '0;
        any = |req;
        if (msb_first) begin
            for (int i = 0; i < REQ_W; i++) begin
                if (req[i]) idx = IDX_W'(i);
            end
        end else begin
            for (int i = REQ_W - 1; i >= 0; i--) begin
                if (req[i]) idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/encoder_16x4.sv
// Captures a 16-bit request vector and streams out the index of
// every set bit, one per accepted transfer, in priority order.
module encoder_16x4
    import encoder_pkg::*;
#(
    parameter int MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [REQ_W-1:0] in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out,
    output logic             out_last,
    output logic             zero_err,
    output logic [CNT_W-1:0] count
);

    localparam logic MSB = (MSB_FIRST != 0);

    state_t           state_q;
    state_t           state_d;
    logic [REQ_W-1:0] pending_q;
    logic [REQ_W-1:0] pending_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             zero_q;
    logic             zero_d;

    logic [IDX_W-1:0] idx;
    logic             any;
    logic             capture;
    logic             fire;
    logic             last;

    encoder_16x4_prio u_prio (
        .req       (pending_q),
        .msb_first (MSB),
        .idx       (idx),
        .any       (any)
    );

    // Handshake and output decode from the registered state only,
    // so no output depends combinationally on an input.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DRAIN) && any;
        out       = out_valid ? idx : '0;
        last      = (count_q == CNT_W'(1));
        out_last  = out_valid && last;
        zero_err  = zero_q;
        count     = count_q;
        capture   = in_valid && in_ready;
        fire      = out_valid && out_ready;
    end

    // Next-state logic: capture in IDLE, retire one bit per
    // accepted transfer in DRAIN, leave after the last one.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        count_d   = count_q;
        zero_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (capture) begin
                    pending_d = in;
                    count_d   = popcount(in);
                    if (in == '0) begin
                        zero_d = 1'b1;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (fire) begin
                    pending_d = pending_q & ~onehot(idx);
                    count_d   = count_q - CNT_W'(1);
                    if (last) state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset discards any pending request bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            count_q   <= '0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            count_q   <= count_d;
            zero_q    <= zero_d;
        end
    end

endmodule

// File: tb/tb_encoder_16x4.sv
// Bench for encoder_16x4: both priority directions side by side
// against a queue model, plus directed literal scenarios.
module tb_encoder_16x4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] din = '0;
    logic        out_ready = 1'b0;

    logic        rdy0, v0, l0, z0;
    logic [3:0]  o0;
    logic [4:0]  c0;
    logic        rdy1, v1, l1, z1;
    logic [3:0]  o1;
    logic [4:0]  c1;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    encoder_16x4 #(.MSB_FIRST(0)) dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(rdy0), .in(din),
        .out_valid(v0), .out_ready(out_ready), .out(o0),
        .out_last(l0), .zero_err(z0), .count(c0)
    );

    encoder_16x4 #(.MSB_FIRST(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(rdy1), .in(din),
        .out_valid(v1), .out_ready(out_ready), .out(o1),
        .out_last(l1), .zero_err(z1), .count(c1)
    );

    // Model: remaining indices, ascending (lsb-first) and
    // descending (msb-first); the head is the next emitted index.
    int qa[$];
    int qd[$];
    bit mz = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            qa.delete();
            qd.delete();
            mz = 1'b0;
        end else begin
            mz = 1'b0;
            if (qa.size() == 0) begin
                if (in_valid) begin
                    for (int i = 0; i < 16; i++)
                        if (din[i]) qa.push_back(i);
                    for (int i = 15; i >= 0; i--)
                        if (din[i]) qd.push_back(i);
                    mz = (din == 16'h0000);
                end
            end else if (out_ready) begin
                void'(qa.pop_front());
                void'(qd.pop_front());
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Cycle-by-cycle compare of both instances against the model.
    always @(negedge clk) begin
        int n;
        n = qa.size();
        vecs++;
        chk("a.valid", v0, n > 0);
        chk("a.ready", rdy0, n == 0);
        chk("a.out", o0, n > 0 ? qa[0] : 0);
        chk("a.last", l0, n == 1);
        chk("a.count", c0, n);
        chk("a.zero", z0, mz);
        chk("d.valid", v1, n > 0);
        chk("d.ready", rdy1, n == 0);
        chk("d.out", o1, n > 0 ? qd[0] : 0);
        chk("d.last", l1, n == 1);
        chk("d.count", c1, n);
        chk("d.zero", z1, mz);
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic capture(input logic [15:0] v);
        int n;
        n = 0;
        while (!rdy0 && n < 64) begin
            cyc();
            n++;
        end
        chk("cap.ready", rdy0, 1);
        in_valid = 1'b1;
        din = v;
        cyc();
        in_valid = 1'b0;
    endtask

    int seq8421[4] = '{0, 5, 10, 15};

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        repeat (3) cyc();
        chk("rst.ready", rdy0, 1);
        chk("rst.valid", v0, 0);
        chk("rst.out", o0, 0);
        chk("rst.count", c0, 0);
        chk("rst.zero", z0, 0);
        rst = 1'b0;
        out_ready = 1'b1;
        cyc();

        capture(16'h0001);
        chk("one.valid", v0, 1);
        chk("one.out", o0, 0);
        chk("one.last", l0, 1);
        chk("one.count", c0, 1);
        cyc();
        chk("one.ready", rdy0, 1);
        chk("one.idle", v0, 0);

        capture(16'h8421);
        for (int k = 0; k < 4; k++) begin
            chk("s8421.valid", v0, 1);
            chk("s8421.out", o0, seq8421[k]);
            chk("s8421.last", l0, k == 3);
            cyc();
        end
        chk("s8421.done", v0, 0);

        capture(16'hFFFF);
        for (int k = 0; k < 16; k++) begin
            chk("ffff.valid", v1, 1);
            chk("ffff.out", o1, 15 - k);
            chk("ffff.count", c1, 16 - k);
            chk("ffff.lsb", o0, k);
            cyc();
        end
        chk("ffff.done", v1, 0);

        capture(16'h0000);
        chk("zero.pulse", z0, 1);
        chk("zero.valid", v0, 0);
        chk("zero.ready", rdy0, 1);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("zero.low", z0, 0);
            chk("zero.novalid", v0, 0);
            chk("zero.rdy", rdy0, 1);
        end

        out_ready = 1'b0;
        capture(16'h0030);
        for (int k = 0; k < 3; k++) begin
            chk("hold.out", o0, 4);
            chk("hold.valid", v0, 1);
            chk("hold.last", l0, 0);
            chk("hold.count", c0, 2);
            cyc();
        end
        out_ready = 1'b1;
        chk("hold.out4", o0, 4);
        cyc();
        chk("hold.out5", o0, 5);
        chk("hold.last5", l0, 1);
        cyc();
        chk("hold.done", v0, 0);

        capture(16'h00F0);
        chk("rst.first", o0, 4);
        cyc();
        chk("rst.second", o0, 5);
        rst = 1'b1;
        #1;
        chk("arst.valid", v0, 0);
        chk("arst.out", o0, 0);
        chk("arst.count", c0, 0);
        chk("arst.ready", rdy0, 1);
        chk("arst.last", l0, 0);
        cyc();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("arst.quiet", v0, 0);
        end

        for (int n = 0; n < 2000; n++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 7))
                0: din = 16'h0000;
                1: din = 16'hFFFF;
                2: din = 16'(1 << $urandom_range(0, 15));
                default: din = 16'($urandom);
            endcase
            out_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 199) == 0);
            cyc();
        end
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (20) cyc();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vecs, errs);
        $finish;
    end

endmodule
